// File: rtl/gpu_regfile_sb_if.sv
// Register-file bundle: read ports, two writeback ports, issue strobe and scoreboard flags.
// The issue/writeback side uses the master modport and the register file uses the slave modport.
interface gpu_regfile_sb_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 16
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [AW-1:0]     rna, rnb, rnc;
    logic [DATA_W-1:0] qa, qb, qc;
    logic [DATA_W-1:0] DR, AR;
    logic              we_a, we_b;
    logic [AW-1:0]     wn_a, wn_b;
    logic [DATA_W-1:0] d_a, d_b;
    logic              iss_en;
    logic [AW-1:0]     iss_rn;
    logic              busy_a, busy_b, busy_c;
    logic              wr_conflict;

    modport master (
        output rna, rnb, rnc, we_a, wn_a, d_a, we_b, wn_b, d_b, iss_en, iss_rn,
        input  qa, qb, qc, DR, AR, busy_a, busy_b, busy_c, wr_conflict
    );

    modport slave (
        input  rna, rnb, rnc, we_a, wn_a, d_a, we_b, wn_b, d_b, iss_en, iss_rn,
        output qa, qb, qc, DR, AR, busy_a, busy_b, busy_c, wr_conflict
    );
endinterface

// File: rtl/gpu_regfile_sb.sv
// Three-read, two-write register file with per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports and busy flags.
module gpu_regfile_sb #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NREGS   = 16,
    parameter int unsigned AR_IDX  = NREGS - 1,
    parameter bit          ZERO_R0 = 1'b0
) (
    input logic             clk,
    input logic             rst,
    gpu_regfile_sb_if.slave rf
);
    localparam int unsigned AW = $clog2(NREGS);
    localparam logic [AW-1:0] ArIdx = AW'(AR_IDX);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic              wr_conflict_q, wr_conflict_d;

    logic wa_ok, wb_ok, wb_commit, iss_ok;

    // Writes and issues to a hardwired-zero R0 are treated as if they never happened.
    always_comb begin
        wa_ok         = rf.we_a & ~(ZERO_R0 & (rf.wn_a == '0));
        wb_ok         = rf.we_b & ~(ZERO_R0 & (rf.wn_b == '0));
        iss_ok        = rf.iss_en & ~(ZERO_R0 & (rf.iss_rn == '0));
        wr_conflict_d = wa_ok & wb_ok & (rf.wn_a == rf.wn_b);
        wb_commit     = wb_ok & ~wr_conflict_d;
    end

    // Issue wins over writeback so the newly issued instruction owns the register.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (iss_ok && rf.iss_rn == AW'(i)) begin
                busy_d[i] = 1'b1;
            end else if ((wa_ok && rf.wn_a == AW'(i)) || (wb_ok && rf.wn_b == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            busy_q        <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            if (wb_commit) begin
                regs_q[rf.wn_b] <= rf.d_b;
            end
            if (wa_ok) begin
                regs_q[rf.wn_a] <= rf.d_a;
            end
            busy_q        <= busy_d;
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Read path: index 0..2 are ports A..C, index 3 is the AR tap.
    logic [AW-1:0]     rd_idx [4];
    logic [DATA_W-1:0] rd_dat [4];
    logic              rd_busy [3];

    always_comb begin
        rd_idx[0] = rf.rna;
        rd_idx[1] = rf.rnb;
        rd_idx[2] = rf.rnc;
        rd_idx[3] = ArIdx;
        for (int p = 0; p < 4; p++) begin
            rd_dat[p] = regs_q[rd_idx[p]];
`ifdef REGFILE_BYPASS_EN
            if (wb_ok && rf.wn_b == rd_idx[p]) begin
                rd_dat[p] = rf.d_b;
            end
            if (wa_ok && rf.wn_a == rd_idx[p]) begin
                rd_dat[p] = rf.d_a;
            end
`endif
            if (ZERO_R0 && rd_idx[p] == '0) begin
                rd_dat[p] = '0;
            end
        end
        for (int p = 0; p < 3; p++) begin
            rd_busy[p] = busy_q[rd_idx[p]];
`ifdef REGFILE_BYPASS_EN
            if (((wa_ok && rf.wn_a == rd_idx[p]) || (wb_ok && rf.wn_b == rd_idx[p]))
                && !(iss_ok && rf.iss_rn == rd_idx[p])) begin
                rd_busy[p] = 1'b0;
            end
`endif
        end
    end

    assign rf.qa          = rd_dat[0];
    assign rf.qb          = rd_dat[1];
    assign rf.qc          = rd_dat[2];
    assign rf.DR          = rd_dat[0];
    assign rf.AR          = rd_dat[3];
    assign rf.busy_a      = rd_busy[0];
    assign rf.busy_b      = rd_busy[1];
    assign rf.busy_c      = rd_busy[2];
    assign rf.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_gpu_regfile_sb.sv
// Directed bench for gpu_regfile_sb (DATA_W=16, NREGS=16, ZERO_R0=1).
// Expected values for same-cycle reads depend on whether REGFILE_BYPASS_EN is defined.
module tb_gpu_regfile_sb;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    gpu_regfile_sb_if #(.DATA_W(16), .NREGS(16)) rf_if ();

    gpu_regfile_sb #(
        .DATA_W (16),
        .NREGS  (16),
        .AR_IDX (15),
        .ZERO_R0(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rf (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle inputs/outputs away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf_if.we_a   = 1'b0;
        rf_if.we_b   = 1'b0;
        rf_if.iss_en = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        rf_if.rna = '0; rf_if.rnb = '0; rf_if.rnc = '0;
        rf_if.wn_a = '0; rf_if.wn_b = '0; rf_if.iss_rn = '0;
        rf_if.d_a = '0; rf_if.d_b = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;

        // Reset: populate R3 and a busy bit, then reset with a competing write.
        rf_if.we_a = 1'b1; rf_if.wn_a = 4'd3; rf_if.d_a = 16'hBEEF;
        rf_if.iss_en = 1'b1; rf_if.iss_rn = 4'd5;
        tick();
        idle();
        rf_if.rna = 4'd3; rf_if.rnb = 4'd5;
        #1;
        check("pre_rst_qa", rf_if.qa, 32'hBEEF);
        check("pre_rst_busy", rf_if.busy_b, 32'd1);
        rst = 1'b1;
        rf_if.we_a = 1'b1; rf_if.wn_a = 4'd15; rf_if.d_a = 16'h1234;
        tick();
        rst = 1'b0;
        idle();
        #1;
        check("rst_qa", rf_if.qa, 32'h0);
        check("rst_dr", rf_if.DR, 32'h0);
        check("rst_ar", rf_if.AR, 32'h0);
        check("rst_busy_b", rf_if.busy_b, 32'd0);
        check("rst_conflict", rf_if.wr_conflict, 32'd0);

        // Dual write to distinct targets.
        rf_if.we_a = 1'b1; rf_if.wn_a = 4'd2; rf_if.d_a = 16'h1111;
        rf_if.we_b = 1'b1; rf_if.wn_b = 4'd5; rf_if.d_b = 16'h2222;
        tick();
        idle();
        rf_if.rna = 4'd2; rf_if.rnb = 4'd5;
        #1;
        check("dual_qa", rf_if.qa, 32'h1111);
        check("dual_qb", rf_if.qb, 32'h2222);
        check("dual_conflict", rf_if.wr_conflict, 32'd0);

        // Collision on R7: A wins, flag lasts one cycle.
        rf_if.we_a = 1'b1; rf_if.wn_a = 4'd7; rf_if.d_a = 16'hAAAA;
        rf_if.we_b = 1'b1; rf_if.wn_b = 4'd7; rf_if.d_b = 16'h5555;
        tick();
        idle();
        rf_if.rnc = 4'd7;
        #1;
        check("coll_qc", rf_if.qc, 32'hAAAA);
        check("coll_flag", rf_if.wr_conflict, 32'd1);
        tick();
        check("coll_flag_drop", rf_if.wr_conflict, 32'd0);
        check("coll_qc_hold", rf_if.qc, 32'hAAAA);

        // Scoreboard on R4.
        rf_if.iss_en = 1'b1; rf_if.iss_rn = 4'd4;
        tick();
        idle();
        rf_if.rna = 4'd4;
        #1;
        check("sb_set", rf_if.busy_a, 32'd1);
        rf_if.we_b = 1'b1; rf_if.wn_b = 4'd4; rf_if.d_b = 16'h4444;
        tick();
        idle();
        #1;
        check("sb_clr", rf_if.busy_a, 32'd0);
        check("sb_clr_data", rf_if.qa, 32'h4444);
        rf_if.iss_en = 1'b1; rf_if.iss_rn = 4'd4;
        rf_if.we_a = 1'b1; rf_if.wn_a = 4'd4; rf_if.d_a = 16'h4A4A;
        tick();
        idle();
        #1;
        check("sb_iss_wins", rf_if.busy_a, 32'd1);
        check("sb_iss_data", rf_if.qa, 32'h4A4A);

        // AR tap and hardwired-zero R0.
        rf_if.we_a = 1'b1; rf_if.wn_a = 4'd15; rf_if.d_a = 16'h00F0;
        tick();
        idle();
        #1;
        check("ar_tap", rf_if.AR, 32'h00F0);
        rf_if.we_a = 1'b1; rf_if.wn_a = 4'd0; rf_if.d_a = 16'h1234;
        rf_if.we_b = 1'b1; rf_if.wn_b = 4'd0; rf_if.d_b = 16'h4321;
        rf_if.iss_en = 1'b1; rf_if.iss_rn = 4'd0;
        rf_if.rna = 4'd0;
        #1;
        check("r0_same_cycle", rf_if.qa, 32'h0);
        tick();
        idle();
        #1;
        check("r0_read", rf_if.qa, 32'h0);
        check("r0_busy", rf_if.busy_a, 32'd0);
        check("r0_no_conflict", rf_if.wr_conflict, 32'd0);

        // Bypass: R9 holds 0x0009 and is busy, then A writes 0xCAFE.
        rf_if.we_a = 1'b1; rf_if.wn_a = 4'd9; rf_if.d_a = 16'h0009;
        rf_if.iss_en = 1'b1; rf_if.iss_rn = 4'd9;
        tick();
        idle();
        rf_if.rnb = 4'd9; rf_if.rnc = 4'd9;
        rf_if.we_a = 1'b1; rf_if.wn_a = 4'd9; rf_if.d_a = 16'hCAFE;
        rf_if.we_b = 1'b1; rf_if.wn_b = 4'd9; rf_if.d_b = 16'hBBBB;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_qb", rf_if.qb, 32'hCAFE);
        check("byp_busy_b", rf_if.busy_b, 32'd0);
`else
        check("byp_qb", rf_if.qb, 32'h0009);
        check("byp_busy_b", rf_if.busy_b, 32'd1);
`endif
        tick();
        idle();
        #1;
        check("byp_after_qc", rf_if.qc, 32'hCAFE);
        check("byp_after_busy", rf_if.busy_c, 32'd0);
        check("byp_after_conflict", rf_if.wr_conflict, 32'd1);

        // B-only write to R9.
        rf_if.we_b = 1'b1; rf_if.wn_b = 4'd9; rf_if.d_b = 16'hBBBB;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_b_qc", rf_if.qc, 32'hBBBB);
`else
        check("byp_b_qc", rf_if.qc, 32'hCAFE);
`endif
        tick();
        idle();
        #1;
        check("b_write_qc", rf_if.qc, 32'hBBBB);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gpu_regfile_sb.md
Name: gpu_regfile_sb

Overview:
- Parametrised successor to the 16x16 three-read/one-write register file.
- Adds a second write port with fixed priority, a per-register scoreboard (pending-write busy bits), synchronous clear, an optional hardwired-zero R0 and optional write-to-read bypass.
- Sits between the decode/issue stage and the ALU/memory writeback paths of the tinyGPU core.
- Keeps the DR and AR taps used by the memory unit.

Parameters:
- DATA_W, 16, register width in bits.
- NREGS, 16, number of registers; power of two, at least 4. Localparam AW = $clog2(NREGS).
- AR_IDX, NREGS-1, index of the register driven on AR.
- ZERO_R0, 0, 1 = register 0 reads as zero and ignores writes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rna, rnb, rnc  in  AW  read port A/B/C register numbers.
- qa, qb, qc  out  DATA_W  read data for ports A/B/C.
- DR  out  DATA_W  data-register tap; equals qa.
- AR  out  DATA_W  address-register tap; contents of register AR_IDX.
- we_a  in  1  write enable, port A (ALU writeback, high priority).
- wn_a  in  AW  port A register number.
- d_a  in  DATA_W  port A write data.
- we_b  in  1  write enable, port B (memory writeback, low priority).
- wn_b  in  AW  port B register number.
- d_b  in  DATA_W  port B write data.
- iss_en  in  1  issue strobe; marks register iss_rn pending.
- iss_rn  in  AW  destination register of the issued instruction.
- busy_a, busy_b, busy_c  out  1  scoreboard bit of rna/rnb/rnc.
- wr_conflict  out  1  registered flag: A and B wrote the same register in the previous cycle.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - all registers go to 0; all busy bits go to 0; wr_conflict goes to 0.
  - rst overrides any write or issue in the same cycle.
  - Mid-operation reset drops pending scoreboard state with no writeback.
- Reads:
  - combinational from storage; zero-cycle latency.
  - qa/qb/qc/DR/AR show post-reset zeros in the cycle after reset.
- Writes:
  - take effect at the rising edge when we_x=1; visible on reads the following cycle (without BYPASS_EN).
- Write collision (we_a & we_b & wn_a==wn_b):
  - port A data is stored; port B is dropped.
  - wr_conflict=1 for exactly the next cycle; otherwise 0.
  - Distinct targets both commit in the same edge.
- ZERO_R0=1:
  - writes to register 0 are discarded and do not raise wr_conflict.
  - Reads of register 0 (any port, and AR if AR_IDX=0) return 0.
  - Issue to register 0 never sets busy.
- Scoreboard, per register r at each edge (rst=0):
  - set if iss_en & iss_rn==r;
  - else clear if (we_a & wn_a==r) | (we_b & wn_b==r);
  - else hold.
  - Issue and writeback to the same register in the same cycle leave busy=1: the new instruction owns it.
  - busy_a/b/c = busy[rna]/busy[rnb]/busy[rnc], combinational.
  - Writes to non-busy registers are legal and simply store.
- Address range:
  - all indices are AW bits wide, so out-of-range access is impossible.
  - Wrap-around is not applicable.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - a read port whose index matches an enabled same-cycle write returns that write's data combinationally; port A takes priority on collision.
  - This applies to qa, qb, qc, DR and AR.
  - busy_x reads 0 when a same-cycle write to that register is present and no same-cycle issue targets it.
  - ZERO_R0 masking still applies.
- Undefined:
  - reads return stored contents only; a written value appears one cycle after the write edge.
  - busy_x reflects registered state only.

Test Plan:
- Reset: write 0xBEEF to R3, assert rst one cycle -> qa(rna=3)=0x0000, AR=0, all busy=0, wr_conflict=0.
- Dual write, distinct targets: we_a R2=0x1111, we_b R5=0x2222 same cycle -> next cycle qa(R2)=0x1111, qb(R5)=0x2222, wr_conflict=0.
- Collision: we_a R7=0xAAAA, we_b R7=0x5555 -> next cycle qc(R7)=0xAAAA, wr_conflict=1 for exactly one cycle.
- Scoreboard:
  - iss_en R4 -> busy_a(rna=4)=1 next cycle;
  - writeback via port B -> 0 next cycle;
  - simultaneous iss_en R4 and we_a R4 -> busy stays 1, data stored.
- AR tap and ZERO_R0=1: write 0x00F0 to R15 -> AR=0x00F0; write 0x1234 to R0 -> qa(R0)=0; iss R0 -> busy 0.
- REGFILE_BYPASS_EN: we_a R9=0xCAFE with rnb=9 same cycle -> qb=0xCAFE that cycle with the macro; previous value without it.
